instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage feeding the decode/control stage. Keeps the PC, issues word requests to instruction memory over a valid/ready channel, and buffers in-order responses in a small FIFO. Presents each instruction with its PC and pre-sliced opcode/func3/func7/register fields to decode over a valid/ready handshake. A taken branch or jump redirect from execute flushes all wrong-path work.

## Interface
- `XLEN`, 32: address/data width
- `RESET_PC`, 32'h0000_0000: first fetch address
- `FIFO_DEPTH`, 4: response buffer entries and maximum in-flight requests (≥2)

- `clk`  in  1  — sole clock; all state on rising edge
- `rst_n`  in  1  — reset, synchronous, active-low
- `imem_req_valid`  out  1  — fetch request valid
- `imem_req_ready`  in  1  — memory accepts request
- `imem_req_addr`  out  XLEN  — word-aligned fetch address
- `imem_rsp_valid`  in  1  — response valid; no backpressure, responses in request order, ≥1 cycle after acceptance
- `imem_rsp_data`  in  XLEN  — instruction word
- `redirect_valid`  in  1  — branch/jump taken
- `redirect_pc`  in  XLEN  — new PC; bits [1:0] ignored (forced 0)
- `id_valid`  out  1  — instruction available to decode
- `id_ready`  in  1  — decode accepts
- `id_pc`, `id_instr`  out  XLEN each  — instruction address and word
- `id_opcode` 7, `id_func3` 3, `id_func7` 7, `id_rd` 5, `id_rs1` 5, `id_rs2` 5  out  — slices of `id_instr` ([6:0], [14:12], [31:25], [11:7], [19:15], [24:20])

## Operation
- Registers: `fetch_pc` (next request address), `rsp_pc` (PC of next accepted response), `inflight` (0..FIFO_DEPTH), `discard` (0..FIFO_DEPTH), FIFO of {pc, instr}.
- Reset values: `fetch_pc`=`rsp_pc`=RESET_PC, counters 0, FIFO empty; `imem_req_valid`=0, `id_valid`=0, all data outputs 0.
- Credit: `imem_req_valid` = 1 iff `inflight + fifo_count < FIFO_DEPTH` and not `redirect_valid`. The FIFO therefore never overflows.
- Request handshake (`valid && ready`): `inflight`+1, `fetch_pc`+4 (wraps modulo 2^XLEN).
- Response: `inflight`−1. If `discard`>0, the data is dropped and `discard`−1. Otherwise {`rsp_pc`, data} is pushed and `rsp_pc`+4.
- Decode handshake: pop the FIFO head. `id_*` come from the FIFO head.
- Redirect (priority over everything):
  - `fetch_pc`=`rsp_pc`=`redirect_pc & ~3`; FIFO flushed.
  - `discard` = `inflight` after this cycle's updates. A response arriving in the same cycle is dropped; a request accepted in the same cycle cannot occur because valid is gated.
  - `id_valid` is forced low combinationally in the redirect cycle, so no wrong-path handshake happens.
- Back-to-back redirects: the last one wins; discard accounting stays exact.
- Reset mid-operation: all state returns to reset values. The memory side is reset by the same `rst_n`, so stale responses cannot arrive.

## Timing
- First request: the cycle after `rst_n` is sampled high, `imem_req_valid`=1 with addr=RESET_PC.
- Latency: memory response in cycle t → `id_valid` in t+1 (registered FIFO, no bypass).
- Redirect at cycle t → request to the new PC in t+1 (if credit allows). The first new-path instruction reaches `id_valid` at the earliest in t+3 with a 1-cycle memory.
- Throughput: with 1-cycle memory latency, always-ready memory and `id_ready`=1, FIFO_DEPTH≥3 sustains one instruction per cycle.
- Decode stall: `id_*` hold stable while `id_valid && !id_ready`. Requests stop once credits run out.

## Structure
- Shared package `riscv_pkg`:
  - XLEN
  - opcode constants (OP_RTYPE 7'b0110011, OP_ITYPE 7'b0010011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011, OP_JAL 7'b1101111, OP_LUI 7'b0110111)
  - field bit positions
  - the instruction-field struct used by both fetch and decode
- Sub-module `fetch_fifo`: synchronous FIFO with parameterised width/depth, push/pop/flush, count output. Simultaneous push+pop when full is not needed because credits prevent it.

## Test plan
- Reset release, memory ready with 1-cycle latency, `id_ready`=1 → requests 0x0, 0x4, 0x8… on consecutive cycles. `id_pc` matches each address. Steady state gives one `id_valid` per cycle.
- Response 0x00208033 (add x0,x1,x2) → `id_opcode`=0110011, `id_func3`=000, `id_func7`=0000000, `id_rs1`=1, `id_rs2`=2, `id_rd`=0.
- `id_ready`=0 for 10 cycles → at most FIFO_DEPTH requests outstanding plus buffered. `id_*` stable. No response lost when ready returns; PCs are contiguous.
- Redirect to 0x103 while 2 requests are in flight, with one response arriving the same cycle → all 3 old responses dropped. Next request addr=0x100. Next `id_pc`=0x100.
- Memory with random `imem_req_ready` stalls and 1–3 cycle latency plus random redirects → scoreboard confirms `id_pc`/`id_instr` pairs are correct and in order, with no wrong-path instruction after any redirect.
- `rst_n` low mid-stream with a full FIFO → next cycle `id_valid`=0, `imem_req_valid`=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by fetch and decode: word width, major
// opcodes, instruction field positions and the field-split helper.
package riscv_pkg;

   localparam int XLEN = 32;

   // Major opcodes recognised by decode
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // Field bit positions inside a 32-bit instruction word
   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int RD_LSB     = 7;
   localparam int RD_MSB     = 11;
   localparam int FUNC3_LSB  = 12;
   localparam int FUNC3_MSB  = 14;
   localparam int RS1_LSB    = 15;
   localparam int RS1_MSB    = 19;
   localparam int RS2_LSB    = 20;
   localparam int RS2_MSB    = 24;
   localparam int FUNC7_LSB  = 25;
   localparam int FUNC7_MSB  = 31;

   typedef struct packed {
      logic [6:0] func7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] func3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } instr_fields_t;

   // Pull the fixed-position fields out of an instruction word
   function automatic instr_fields_t split_instr(input logic [31:0] instr);
      instr_fields_t f;
      f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
      f.rd     = instr[RD_MSB:RD_LSB];
      f.func3  = instr[FUNC3_MSB:FUNC3_LSB];
      f.rs1    = instr[RS1_MSB:RS1_LSB];
      f.rs2    = instr[RS2_MSB:RS2_LSB];
      f.func7  = instr[FUNC7_MSB:FUNC7_LSB];
      return f;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs. The head entry is
// presented combinationally. Flush empties it in one cycle and wins over
// push/pop; push into a full FIFO is ignored (the fetch credit scheme never
// attempts it).
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (count_q != CW'(DEPTH));
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next pointer/occupancy values; flush discards everything
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset because count gates the head
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: tracks the PC, issues credit-limited word requests
// to instruction memory, tags in-order responses with their PC and hands them
// to decode through a small FIFO. A redirect flushes the FIFO and arranges for
// every response still in flight to be dropped on arrival.
module instr_fetch #(
   parameter int              XLEN       = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_instr,
   output logic [6:0]      id_opcode,
   output logic [2:0]      id_func3,
   output logic [6:0]      id_func7,
   output logic [4:0]      id_rd,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2
);

   import riscv_pkg::instr_fields_t;
   import riscv_pkg::split_instr;

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int FW = 2 * XLEN;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic            run_q;

   logic [CW-1:0]   fifo_count;
   logic            fifo_empty;
   logic [FW-1:0]   fifo_head;
   logic            credit_ok;
   logic            req_fire;
   logic            rsp_keep;
   logic            id_fire;
   logic [XLEN-1:0] redirect_tgt;
   instr_fields_t   fields;

   // A slot is free when requests in flight plus buffered entries leave room,
   // so every response is guaranteed a FIFO entry.
   assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);

   assign imem_req_valid = run_q && credit_ok && !redirect_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses owed to a superseded path are dropped while discard is nonzero
   assign rsp_keep     = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
   assign redirect_tgt = redirect_pc & ~XLEN'(3);

   assign id_valid = !fifo_empty && !redirect_valid;
   assign id_fire  = id_valid && id_ready;

   // Outputs read as zero while nothing is buffered
   assign id_pc    = fifo_empty ? '0 : fifo_head[FW-1:XLEN];
   assign id_instr = fifo_empty ? '0 : fifo_head[XLEN-1:0];

   assign fields    = split_instr(id_instr[31:0]);
   assign id_opcode = fields.opcode;
   assign id_func3  = fields.func3;
   assign id_func7  = fields.func7;
   assign id_rd     = fields.rd;
   assign id_rs1    = fields.rs1;
   assign id_rs2    = fields.rs2;

   fetch_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (rsp_keep),
      .push_data_i ({rsp_pc_q, imem_rsp_data}),
      .pop_i       (id_fire),
      .flush_i     (redirect_valid),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Next PCs and counters; a redirect overrides the PCs and turns whatever is
   // still in flight after this cycle into responses to throw away.
   always_comb begin
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
      discard_d  = discard_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_keep) rsp_pc_d = rsp_pc_q + XLEN'(4);
      if (redirect_valid) begin
         fetch_pc_d = redirect_tgt;
         rsp_pc_d   = redirect_tgt;
         discard_d  = inflight_d;
      end
   end

   // Fetch state registers; run_q holds off requests until reset has released
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         run_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         run_q      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a behavioural instruction memory with random
// acceptance stalls and 1-3 cycle in-order latency, plus a program-order
// scoreboard. The expected stream is simply "sequential PCs from the last
// redirect target (or reset PC), each paired with the memory word at that PC".
module tb_instr_fetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid, id_ready;
   logic [31:0] id_pc, id_instr;
   logic [6:0]  id_opcode, id_func7;
   logic [2:0]  id_func3;
   logic [4:0]  id_rd, id_rs1, id_rs2;

   always #5 clk = ~clk;

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_instr(id_instr),
      .id_opcode(id_opcode), .id_func3(id_func3), .id_func7(id_func7),
      .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2)
   );

   typedef struct { logic [31:0] addr; int due; } pend_t;
   pend_t pq[$];

   int tests = 0, fails = 0;
   int cyc = 0, last_due = 0;
   int rdy_pct = 100, idr_pct = 100, lat_min = 1, lat_max = 1, redir_pm = 0;
   bit rst_val = 1'b0;
   int n_req = 0, n_id = 0, live = 0;
   logic [31:0] exp_pc = 32'h0, exp_req = 32'h0;

   // Memory contents: one known add at 0x8, a hash elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8) return 32'h0020_8033;
      return (a * 32'h9E37_79B1) ^ 32'hA5C3_1E07 ^ {a[15:0], a[31:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, observe 1 time unit later
   task automatic cycle(input bit force_redir, input logic [31:0] tgt);
      logic [31:0] w;
      int lat, due;
      @(negedge clk);
      cyc++;
      rst_n          = rst_val;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      id_ready       = ($urandom_range(99) < idr_pct);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if (rst_n) begin
         if (pq.size() > 0 && pq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pq[0].addr);
            pq.delete(0);
         end
         if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
         end else if ($urandom_range(999) < redir_pm) begin
            redirect_valid = 1'b1;
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else                        redirect_pc = 32'($urandom_range(1023));
         end
      end
      #1;
      if (!rst_n) begin
         pq.delete();
         last_due = 0;
         live     = 0;
         exp_pc   = 32'h0;
         exp_req  = 32'h0;
      end else begin
         if (redirect_valid) begin
            chk("redir_id_valid_low", 32'(id_valid), 32'h0);
            chk("redir_req_valid_low", 32'(imem_req_valid), 32'h0);
         end
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            exp_req = exp_req + 32'h4;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pq.push_back('{addr: imem_req_addr, due: due});
            n_req++;
            live++;
         end
         if (id_valid && id_ready) begin
            w = mem_word(exp_pc);
            chk("id_pc", id_pc, exp_pc);
            chk("id_instr", id_instr, w);
            chk("id_opcode", 32'(id_opcode), 32'(w[6:0]));
            chk("id_rd", 32'(id_rd), 32'(w[11:7]));
            chk("id_func3", 32'(id_func3), 32'(w[14:12]));
            chk("id_rs1", 32'(id_rs1), 32'(w[19:15]));
            chk("id_rs2", 32'(id_rs2), 32'(w[24:20]));
            chk("id_func7", 32'(id_func7), 32'(w[31:25]));
            if (exp_pc == 32'h8) begin
               chk("add_opcode", 32'(id_opcode), 32'h33);
               chk("add_func3", 32'(id_func3), 32'h0);
               chk("add_func7", 32'(id_func7), 32'h0);
               chk("add_rs1", 32'(id_rs1), 32'h1);
               chk("add_rs2", 32'(id_rs2), 32'h2);
               chk("add_rd", 32'(id_rd), 32'h0);
            end
            exp_pc = exp_pc + 32'h4;
            n_id++;
            live--;
         end
         if (redirect_valid) begin
            exp_pc  = redirect_pc & 32'hFFFF_FFFC;
            exp_req = redirect_pc & 32'hFFFF_FFFC;
            live    = 0;
         end
      end
   endtask

   initial begin
      int n0_id, n0_req;
      bit have, found, got;
      logic [31:0] st_pc, st_instr;

      rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

      // Reset state
      rst_val = 1'b0;
      repeat (3) cycle(1'b0, 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_id_valid", 32'(id_valid), 32'h0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instr, 32'h0);
      chk("rst_id_opcode", 32'(id_opcode), 32'h0);

      // Release: first request one cycle after rst_n is sampled high
      rst_val = 1'b1;
      cycle(1'b0, 32'h0);
      cycle(1'b0, 32'h0);
      chk("first_req_valid", 32'(imem_req_valid), 32'h1);
      chk("first_req_addr", imem_req_addr, 32'h0);

      // Steady state with 1-cycle memory: one instruction per cycle
      repeat (8) cycle(1'b0, 32'h0);
      n0_id = n_id; n0_req = n_req;
      repeat (10) cycle(1'b0, 32'h0);
      chk("tput_id", 32'(n_id - n0_id), 32'd10);
      chk("tput_req", 32'(n_req - n0_req), 32'd10);

      // Decode stall: outputs hold, credits cap outstanding work
      idr_pct = 0; have = 1'b0; st_pc = '0; st_instr = '0;
      repeat (10) begin
         cycle(1'b0, 32'h0);
         chk("stall_outstanding_le_depth", 32'(live <= DEPTH), 32'h1);
         chk("stall_id_valid", 32'(id_valid), 32'h1);
         if (!have) begin
            st_pc = id_pc; st_instr = id_instr; have = 1'b1;
         end else begin
            chk("stall_id_pc_stable", id_pc, st_pc);
            chk("stall_id_instr_stable", id_instr, st_instr);
         end
      end
      chk("stall_outstanding_full", 32'(live), 32'(DEPTH));
      idr_pct = 100;
      repeat (15) cycle(1'b0, 32'h0);

      // Redirect to 0x103 with >=2 requests in flight, one responding now
      lat_min = 3; lat_max = 3;
      repeat (10) cycle(1'b0, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (pq.size() >= 2 && pq[0].due <= cyc + 1) found = 1'b1;
         else cycle(1'b0, 32'h0);
      end
      chk("redir_setup_found", 32'(found), 32'h1);
      cycle(1'b1, 32'h103);
      cycle(1'b0, 32'h0);
      chk("redir_next_req_valid", 32'(imem_req_valid), 32'h1);
      chk("redir_next_req_addr", imem_req_addr, 32'h100);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (id_valid) begin
            got = 1'b1;
            chk("redir_first_id_pc", id_pc, 32'h100);
         end else begin
            cycle(1'b0, 32'h0);
         end
      end
      chk("redir_first_id_seen", 32'(got), 32'h1);

      // Random stalls, latencies and redirects
      rdy_pct = 70; idr_pct = 70; lat_min = 1; lat_max = 3; redir_pm = 20;
      n0_id = n_id;
      repeat (1500) cycle(1'b0, 32'h0);
      chk("random_progress", 32'(n_id - n0_id > 100), 32'h1);

      // Reset with a full FIFO
      rdy_pct = 100; idr_pct = 0; lat_min = 1; lat_max = 1; redir_pm = 0;
      repeat (12) cycle(1'b0, 32'h0);
      chk("prereset_full", 32'(live), 32'(DEPTH));
      chk("prereset_id_valid", 32'(id_valid), 32'h1);
      rst_val = 1'b0;
      cycle(1'b0, 32'h0);
      rst_val = 1'b1;
      cycle(1'b0, 32'h0);
      chk("midrst_id_valid", 32'(id_valid), 32'h0);
      chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("midrst_id_pc", id_pc, 32'h0);
      idr_pct = 100;
      cycle(1'b0, 32'h0);
      chk("restart_req_valid", 32'(imem_req_valid), 32'h1);
      chk("restart_req_addr", imem_req_addr, 32'h0);
      n0_id = n_id;
      repeat (20) cycle(1'b0, 32'h0);
      chk("restart_progress", 32'(n_id - n0_id >= 15), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
